// File: rtl/csi_rx_pwrup_seq.sv
`default_nettype none
// ============================================================================
// Module      : csi_rx_pwrup_seq
// Description : Power-up and recovery sequencer for the CSI-2 D-PHY receiver.
//               Releases D-PHY power-down, then the core/LP resets, then the
//               byte-clock resets, each step qualified by a filtered PLL lock.
//               Retries on lock timeout, re-sequences on lock loss and reports
//               ready / sticky fail to the system controller.
// Ports       : clk_lp_ctrl_i      LP control clock (only clock)
//               reset_i            async active-high reset
//               en_i               run request (1 = bring up, 0 = power down)
//               pll_lock_i         async PLL lock, synchronised internally
//               cfg_ld_i           reload pulse for ref_dt_o (RUN only)
//               ref_dt_cfg_i[5:0]  requested reference data type
//               pd_dphy_o          D-PHY power-down (1 = down)
//               reset_n_o          core reset, active low
//               reset_lp_n_o       LP logic reset, active low
//               reset_byte_n_o     byte clock reset, active low
//               reset_byte_fr_n_o  free-running byte clock reset, active low
//               ref_dt_o[5:0]      reference data type to the IP
//               ready_o            high only in RUN
//               fail_o             sticky failure flag
//               retry_cnt_o        lock timeouts in the current bring-up
// Revision    : 1.0 - initial release
// ============================================================================
module csi_rx_pwrup_seq #(
  parameter int PD_CYCLES        = 16,
  parameter int LOCK_TIMEOUT     = 1024,
  parameter int LOCK_FILT        = 4,
  parameter int RST_STAGE_CYCLES = 8,
  parameter int MAX_RETRY        = 3
) (
  input  logic                             clk_lp_ctrl_i,
  input  logic                             reset_i,
  input  logic                             en_i,
  input  logic                             pll_lock_i,
  input  logic                             cfg_ld_i,
  input  logic [5:0]                       ref_dt_cfg_i,
  output logic                             pd_dphy_o,
  output logic                             reset_n_o,
  output logic                             reset_lp_n_o,
  output logic                             reset_byte_n_o,
  output logic                             reset_byte_fr_n_o,
  output logic [5:0]                       ref_dt_o,
  output logic                             ready_o,
  output logic                             fail_o,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt_o
);

  // Counter sized for the longest dwell of any timed state.
  localparam int c_CNT_MAX = (PD_CYCLES > LOCK_TIMEOUT) ?
                             ((PD_CYCLES > RST_STAGE_CYCLES) ? PD_CYCLES : RST_STAGE_CYCLES) :
                             ((LOCK_TIMEOUT > RST_STAGE_CYCLES) ? LOCK_TIMEOUT : RST_STAGE_CYCLES);
  localparam int c_CW = $clog2(c_CNT_MAX + 1);
  localparam int c_FW = $clog2(LOCK_FILT + 1);
  localparam int c_RW = $clog2(MAX_RETRY + 1);

  // "Last" values: a state with N cycles of dwell leaves when the counter,
  // cleared on entry, shows N-1.
  localparam logic [c_CW-1:0] c_PD_LAST   = c_CW'(PD_CYCLES - 1);
  localparam logic [c_CW-1:0] c_TO_LAST   = c_CW'(LOCK_TIMEOUT - 1);
  localparam logic [c_CW-1:0] c_RST_LAST  = c_CW'(RST_STAGE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(LOCK_FILT - 1);
  localparam logic [c_FW-1:0] c_FILT_ONE  = c_FW'(1);
  localparam logic [c_RW-1:0] c_RETRY_MAX = c_RW'(MAX_RETRY);
  localparam logic [c_RW-1:0] c_RETRY_ONE = c_RW'(1);

  localparam logic [2:0] c_ST_OFF       = 3'd0;
  localparam logic [2:0] c_ST_PD_WAIT   = 3'd1;
  localparam logic [2:0] c_ST_LOCK_WAIT = 3'd2;
  localparam logic [2:0] c_ST_RST_CORE  = 3'd3;
  localparam logic [2:0] c_ST_RST_BYTE  = 3'd4;
  localparam logic [2:0] c_ST_RUN       = 3'd5;
  localparam logic [2:0] c_ST_FAIL      = 3'd6;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [c_CW-1:0] r_cnt;
  logic [c_FW-1:0] r_filt;
  logic [c_RW-1:0] r_retry;
  logic            r_lock_meta;
  logic            r_lock_sync;
  logic            r_pd;
  logic            r_rst_core_n;
  logic            r_rst_byte_n;
  logic [5:0]      r_ref_dt;
  logic            r_ready;
  logic            r_fail;

  logic            w_lock_ok;
  logic            w_timeout;
  logic [c_RW-1:0] w_retry_inc;

  // Lock is accepted on the cycle that would make the filter reach LOCK_FILT.
  assign w_lock_ok   = r_lock_sync && (r_filt == c_FILT_LAST);
  assign w_timeout   = (r_state == c_ST_LOCK_WAIT) && (r_cnt == c_TO_LAST);
  assign w_retry_inc = r_retry + c_RETRY_ONE;

  // --------------------------------------------------------------------------
  // Next-state logic. en_i low overrides every other transition.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    if (!en_i) begin
      w_next = c_ST_OFF;
    end else begin
      case (r_state)
        c_ST_OFF:       w_next = c_ST_PD_WAIT;
        c_ST_PD_WAIT:   if (r_cnt == c_PD_LAST) w_next = c_ST_LOCK_WAIT;
        c_ST_LOCK_WAIT: begin
          if (w_lock_ok)
            w_next = c_ST_RST_CORE;
          else if (w_timeout)
            w_next = (w_retry_inc == c_RETRY_MAX) ? c_ST_FAIL : c_ST_PD_WAIT;
        end
        c_ST_RST_CORE: begin
          if (!r_lock_sync)              w_next = c_ST_PD_WAIT;
          else if (r_cnt == c_RST_LAST)  w_next = c_ST_RST_BYTE;
        end
        c_ST_RST_BYTE: begin
          if (!r_lock_sync)              w_next = c_ST_PD_WAIT;
          else if (r_cnt == c_RST_LAST)  w_next = c_ST_RUN;
        end
        c_ST_RUN:       if (!r_lock_sync) w_next = c_ST_PD_WAIT;
        c_ST_FAIL:      w_next = c_ST_FAIL;
        default:        w_next = c_ST_OFF;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State, counters and lock synchroniser.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_lp_ctrl_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= c_ST_OFF;
      r_cnt       <= '0;
      r_filt      <= '0;
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_lock_meta <= pll_lock_i;
      r_lock_sync <= r_lock_meta;

      // Dwell counter restarts on every state change and saturates.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + c_CNT_ONE;

      // Filter only accumulates while remaining in LOCK_WAIT with lock high.
      if ((r_state == c_ST_LOCK_WAIT) && (w_next == c_ST_LOCK_WAIT) && r_lock_sync) begin
        if (r_filt != '1)
          r_filt <= r_filt + c_FILT_ONE;
      end else begin
        r_filt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs decoded from the next state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_lp_ctrl_i or posedge reset_i) begin
    if (reset_i) begin
      r_pd         <= 1'b1;
      r_rst_core_n <= 1'b0;
      r_rst_byte_n <= 1'b0;
      r_ref_dt     <= '0;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
      r_retry      <= '0;
    end else begin
      r_pd         <= (w_next == c_ST_OFF) || (w_next == c_ST_PD_WAIT) ||
                      (w_next == c_ST_FAIL);
      r_rst_core_n <= (w_next == c_ST_RST_CORE) || (w_next == c_ST_RST_BYTE) ||
                      (w_next == c_ST_RUN);
      r_rst_byte_n <= (w_next == c_ST_RST_BYTE) || (w_next == c_ST_RUN);
      r_ready      <= (w_next == c_ST_RUN);
      r_fail       <= (w_next == c_ST_FAIL);

      // Leaving LOCK_WAIT for PD_WAIT or FAIL can only be a timeout.
      if ((w_next == c_ST_OFF) || ((w_next == c_ST_RUN) && (r_state != c_ST_RUN)))
        r_retry <= '0;
      else if ((r_state == c_ST_LOCK_WAIT) &&
               ((w_next == c_ST_PD_WAIT) || (w_next == c_ST_FAIL)))
        r_retry <= w_retry_inc;

      // Load on RUN entry, or on a reload pulse while staying in RUN.
      if ((w_next == c_ST_RUN) && ((r_state != c_ST_RUN) || cfg_ld_i))
        r_ref_dt <= ref_dt_cfg_i;
    end
  end

  assign pd_dphy_o         = r_pd;
  assign reset_n_o         = r_rst_core_n;
  assign reset_lp_n_o      = r_rst_core_n;
  assign reset_byte_n_o    = r_rst_byte_n;
  assign reset_byte_fr_n_o = r_rst_byte_n;
  assign ref_dt_o          = r_ref_dt;
  assign ready_o           = r_ready;
  assign fail_o            = r_fail;
  assign retry_cnt_o       = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_pwrup_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_csi_rx_pwrup_seq
// Description : Self-checking bench for csi_rx_pwrup_seq. Stimulus code
//               queues expected output snapshots tagged with the absolute
//               clock edge after which they must hold; a negedge monitor
//               pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csi_rx_pwrup_seq;

  localparam logic [14:0] M_CTL = 15'h7FC0;  // everything except ref_dt
  localparam logic [14:0] M_ALL = 15'h7FFF;

  typedef struct {
    int          at;
    string       tag;
    logic [14:0] mask;
    logic [14:0] val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       lock;
  logic       cfg_ld;
  logic [5:0] cfg;
  logic       pd, rst_n, lp_n, byte_n, fr_n, ready, fail;
  logic [5:0] ref_dt;
  logic [1:0] retry;
  logic [14:0] obs;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  csi_rx_pwrup_seq dut (
    .clk_lp_ctrl_i     (clk),
    .reset_i           (rst),
    .en_i              (en),
    .pll_lock_i        (lock),
    .cfg_ld_i          (cfg_ld),
    .ref_dt_cfg_i      (cfg),
    .pd_dphy_o         (pd),
    .reset_n_o         (rst_n),
    .reset_lp_n_o      (lp_n),
    .reset_byte_n_o    (byte_n),
    .reset_byte_fr_n_o (fr_n),
    .ref_dt_o          (ref_dt),
    .ready_o           (ready),
    .fail_o            (fail),
    .retry_cnt_o       (retry)
  );

  assign obs = {pd, rst_n, lp_n, byte_n, fr_n, ready, fail, retry, ref_dt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] pat(input logic pd_e, input logic [3:0] r,
                                      input logic rdy, input logic f,
                                      input logic [1:0] rt, input logic [5:0] dt);
    return {pd_e, r, rdy, f, rt, dt};
  endfunction

  task automatic chk(input string tag, input logic [14:0] act, input logic [14:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic exp_at(input int at, input string tag, input logic [14:0] mask,
                        input logic [14:0] val);
    exp_t e;
    e.at   = at;
    e.tag  = tag;
    e.mask = mask;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: compare every expectation due at this edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        chk(sb[i].tag, obs & sb[i].mask, sb[i].val & sb[i].mask);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_to(input int abs_edge);
    while (cyc < abs_edge) @(negedge clk);
  endtask

  // Bring-up with a 3-high/1-low lock pattern, cfg_ld pulse in LOCK_WAIT,
  // then steady lock. With kill=1, en drops in the filter-completion cycle.
  task automatic glitch_run(input bit kill);
    int b;
    b  = cyc;
    en = 1'b1;
    exp_at(b + 17, "lw_entry",       M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 24, "glitch_hold_a",  M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 26, "cfg_ld_ignored", M_ALL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h05));
    exp_at(b + 30, "glitch_hold_b",  M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 37, "filt_pending",   M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    if (kill)
      exp_at(b + 38, "en_low_prio", M_CTL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    else
      exp_at(b + 38, "filt_accept", M_CTL, pat(1'b0, 4'hC, 1'b0, 1'b0, 2'd0, 6'h00));
    for (int i = 0; i < 32; i++) begin
      go_to(b + i);
      lock = ((i % 4) != 3);
      if (i == 25) begin
        cfg    = 6'h3F;
        cfg_ld = 1'b1;
      end else if (i == 26) begin
        cfg_ld = 1'b0;
        cfg    = 6'h05;
      end
    end
    go_to(b + 32);
    lock = 1'b1;
    go_to(b + 37);
    if (kill) en = 1'b0;
    go_to(b + 38);
    en = 1'b0;
    exp_at(b + 39, "off_after_glitch", M_ALL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h05));
    go_to(b + 39);
  endtask

  initial begin
    int b;
    rst    = 1'b1;
    en     = 1'b0;
    lock   = 1'b1;
    cfg_ld = 1'b0;
    cfg    = 6'h2B;
    #2;
    chk("reset_values", obs, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    step(2);
    rst = 1'b0;
    step(3);
    chk("off_idle", obs, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));

    // ---------------- nominal bring-up, reload, lock loss ----------------
    b  = cyc;
    en = 1'b1;
    exp_at(b + 1,  "pd_wait_entry", M_CTL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 16, "pd_held",       M_CTL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 17, "pd_release",    M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 20, "lock_filter",   M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 21, "rst_core",      M_CTL, pat(1'b0, 4'hC, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 28, "rst_core_end",  M_CTL, pat(1'b0, 4'hC, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 29, "rst_byte",      M_CTL, pat(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 36, "rst_byte_end",  M_CTL, pat(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 37, "run_entry",     M_ALL, pat(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 6'h2B));
    go_to(b + 37);
    cfg    = 6'h1E;
    cfg_ld = 1'b1;
    exp_at(b + 38, "cfg_ld_run",    M_ALL, pat(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 6'h1E));
    go_to(b + 38);
    cfg_ld = 1'b0;
    cfg    = 6'h05;
    exp_at(b + 39, "cfg_hold",      M_ALL, pat(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 6'h1E));
    go_to(b + 39);
    lock = 1'b0;
    exp_at(b + 42, "lock_loss",     M_ALL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h1E));
    go_to(b + 42);
    lock = 1'b1;
    exp_at(b + 57, "reseq_pd",      M_CTL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 58, "reseq_lw",      M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 77, "reseq_byte",    M_CTL, pat(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 78, "reseq_run",     M_ALL, pat(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 6'h05));
    go_to(b + 78);
    en = 1'b0;
    exp_at(b + 79, "en_low_off",    M_ALL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h05));
    go_to(b + 79);

    // ---------------- lock glitch filter / en priority ----------------
    glitch_run(1'b0);
    glitch_run(1'b1);

    // ---------------- lock timeouts and FAIL ----------------
    lock = 1'b0;
    step(3);
    b  = cyc;
    en = 1'b1;
    exp_at(b + 1040, "to1_pending", M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 1041, "timeout1",    M_CTL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd1, 6'h00));
    exp_at(b + 2080, "to2_pending", M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd1, 6'h00));
    exp_at(b + 2081, "timeout2",    M_CTL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd2, 6'h00));
    exp_at(b + 3120, "to3_pending", M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd2, 6'h00));
    exp_at(b + 3121, "fail_entry",  M_CTL, pat(1'b1, 4'h0, 1'b0, 1'b1, 2'd3, 6'h00));
    exp_at(b + 3200, "fail_sticky", M_CTL, pat(1'b1, 4'h0, 1'b0, 1'b1, 2'd3, 6'h00));
    go_to(b + 3200);
    en = 1'b0;
    exp_at(b + 3201, "fail_clear",  M_ALL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h05));
    go_to(b + 3201);

    // ---------------- async reset in RST_BYTE ----------------
    lock = 1'b1;
    step(3);
    b  = cyc;
    en = 1'b1;
    exp_at(b + 29, "ar_rst_byte",   M_CTL, pat(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 32, "ar_pre",        M_CTL, pat(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 6'h00));
    go_to(b + 32);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", obs, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    @(negedge clk);
    chk("rst_held", obs, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    rst = 1'b0;
    exp_at(b + 34, "ar_pd_wait",    M_ALL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 49, "ar_pd_end",     M_CTL, pat(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 50, "ar_lock_wait",  M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 53, "ar_filter",     M_CTL, pat(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 54, "ar_rst_core",   M_CTL, pat(1'b0, 4'hC, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 69, "ar_byte_end",   M_CTL, pat(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 6'h00));
    exp_at(b + 70, "ar_run",        M_ALL, pat(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 6'h05));
    go_to(b + 70);
    step(2);

    chk("sb_empty", 15'(sb.size()), 15'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
